// File: rtl/tetris_pkg.sv
// Shared definitions for the piece-movement path: controller states, move kinds
// and the spawn pose that the position register also resets to.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_COMMIT,
        ST_LOCK,
        ST_SPAWN_CHK,
        ST_OVER
    } state_t;

    typedef enum logic [1:0] {
        MV_ROT,
        MV_LEFT,
        MV_RIGHT,
        MV_DOWN
    } move_t;

    localparam logic [9:0] SPAWN_X   = 10'd9;
    localparam logic [9:0] SPAWN_Y   = 10'd0;
    localparam logic [9:0] SPAWN_ROT = 10'd0;

endpackage

// File: rtl/move_ctrl_grav_tick.sv
// Free-running gravity divider: counts 0..GRAV_DIV-1 while enabled and emits a
// one-cycle tick on the cycle the count wraps.
module grav_tick #(
    parameter int unsigned GRAV_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned    CW   = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(GRAV_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/move_ctrl.sv
// Move controller: turns button edges and gravity into candidate poses, has each
// one collision-checked, then commits it, or locks and respawns the piece.
module move_ctrl #(
    parameter int unsigned BOARD_W  = 20,
    parameter int unsigned SPAWN_X  = 9,
    parameter int unsigned GRAV_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic [9:0] cur_x,
    input  logic [9:0] cur_y,
    input  logic [9:0] cur_rot,
    output logic       chk_req,
    output logic [9:0] chk_x,
    output logic [9:0] chk_y,
    output logic [9:0] chk_rot,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic [9:0] next_rot,
    output logic       pos_refresh,
    output logic       pos_respawn,
    output logic       piece_lock,
    output logic       game_over
);
    import tetris_pkg::*;

    localparam logic [9:0] X_MAX   = 10'(BOARD_W - 1);
    localparam logic [9:0] SPAWN_C = 10'(SPAWN_X);

    state_t     state;
    move_t      mv;
    logic [3:0] btn_q;
    logic [3:0] btn_prev;
    logic [3:0] btn_rise;
    logic       grav_pend;
    logic       grav_tick_w;

    logic       acc;
    logic       clr_pend;
    move_t      acc_mv;
    logic [9:0] acc_x;
    logic [9:0] acc_y;
    logic [9:0] acc_rot;

    grav_tick #(
        .GRAV_DIV(GRAV_DIV)
    ) u_grav (
        .clk (clk),
        .rst (rst),
        .en  (state != ST_OVER),
        .tick(grav_tick_w)
    );

    // Bit order {rot, left, right, down} doubles as the priority order.
    assign btn_rise = btn_q & ~btn_prev;

    // Pick the winning request; an edge-blocked move is consumed, not deferred.
    always_comb begin
        acc      = 1'b0;
        clr_pend = 1'b0;
        acc_mv   = MV_ROT;
        acc_x    = cur_x;
        acc_y    = cur_y;
        acc_rot  = cur_rot;
        if (btn_rise[3]) begin
            acc     = 1'b1;
            acc_mv  = MV_ROT;
            acc_rot = {8'b0, cur_rot[1:0] + 2'd1};
        end else if (btn_rise[2]) begin
            acc    = (cur_x != '0);
            acc_mv = MV_LEFT;
            acc_x  = cur_x - 10'd1;
        end else if (btn_rise[1]) begin
            acc    = (cur_x != X_MAX);
            acc_mv = MV_RIGHT;
            acc_x  = cur_x + 10'd1;
        end else if (btn_rise[0] || grav_pend) begin
            acc      = 1'b1;
            clr_pend = 1'b1;
            acc_mv   = MV_DOWN;
            acc_y    = cur_y + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mv          <= MV_ROT;
            btn_q       <= '0;
            btn_prev    <= '0;
            grav_pend   <= 1'b0;
            chk_req     <= 1'b0;
            chk_x       <= '0;
            chk_y       <= '0;
            chk_rot     <= '0;
            next_x      <= '0;
            next_y      <= '0;
            next_rot    <= '0;
            pos_refresh <= 1'b0;
            pos_respawn <= 1'b0;
            piece_lock  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            btn_q       <= {btn_rot, btn_left, btn_right, btn_down};
            btn_prev    <= btn_q;
            pos_refresh <= 1'b0;
            pos_respawn <= 1'b0;
            piece_lock  <= 1'b0;

            // A wrap in the same cycle as an accepted downward move keeps the flag set.
            if (grav_tick_w)
                grav_pend <= 1'b1;
            else if (state == ST_IDLE && acc && clr_pend)
                grav_pend <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (acc) begin
                        mv      <= acc_mv;
                        chk_x   <= acc_x;
                        chk_y   <= acc_y;
                        chk_rot <= acc_rot;
                        chk_req <= 1'b1;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (chk_ack) begin
                        chk_req <= 1'b0;
                        if (!chk_hit) begin
                            next_x      <= chk_x;
                            next_y      <= chk_y;
                            next_rot    <= chk_rot;
                            pos_refresh <= 1'b1;
                            state       <= ST_COMMIT;
                        end else if (mv == MV_DOWN) begin
                            piece_lock  <= 1'b1;
                            pos_respawn <= 1'b1;
                            state       <= ST_LOCK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                ST_LOCK: begin
                    chk_x   <= SPAWN_C;
                    chk_y   <= SPAWN_Y;
                    chk_rot <= SPAWN_ROT;
                    chk_req <= 1'b1;
                    state   <= ST_SPAWN_CHK;
                end
                ST_SPAWN_CHK: begin
                    if (chk_ack) begin
                        chk_req <= 1'b0;
                        if (chk_hit) begin
                            game_over <= 1'b1;
                            state     <= ST_OVER;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_OVER: begin
                    state <= ST_OVER;
                end
                default: begin
                    chk_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl: one instance with slow gravity for button moves,
// one with GRAV_DIV=4 for gravity, lock, respawn and game-over.
module tb_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_a, rst_g;
    logic       btn_left, btn_right, btn_rot, btn_down;
    logic [9:0] cur_x, cur_y, cur_rot;
    logic       ack_a, hit_a, ack_g, hit_g;

    logic       req_a, ref_a, resp_a, lock_a, go_a;
    logic [9:0] cx_a, cy_a, cr_a, nx_a, ny_a, nr_a;
    logic       req_g, ref_g, resp_g, lock_g, go_g;
    logic [9:0] cx_g, cy_g, cr_g, nx_g, ny_g, nr_g;

    logic [4:0] p_a, p_g;
    assign p_a = {req_a, ref_a, resp_a, lock_a, go_a};
    assign p_g = {req_g, ref_g, resp_g, lock_g, go_g};

    int checks = 0;
    int errors = 0;
    logic found;

    always #5 clk = ~clk;

    move_ctrl #(.BOARD_W(20), .SPAWN_X(9), .GRAV_DIV(1000)) dut_a (
        .clk(clk), .rst(rst_a),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_down(btn_down),
        .cur_x(cur_x), .cur_y(cur_y), .cur_rot(cur_rot),
        .chk_req(req_a), .chk_x(cx_a), .chk_y(cy_a), .chk_rot(cr_a),
        .chk_ack(ack_a), .chk_hit(hit_a),
        .next_x(nx_a), .next_y(ny_a), .next_rot(nr_a),
        .pos_refresh(ref_a), .pos_respawn(resp_a), .piece_lock(lock_a), .game_over(go_a)
    );

    move_ctrl #(.BOARD_W(20), .SPAWN_X(9), .GRAV_DIV(4)) dut_g (
        .clk(clk), .rst(rst_g),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_down(btn_down),
        .cur_x(cur_x), .cur_y(cur_y), .cur_rot(cur_rot),
        .chk_req(req_g), .chk_x(cx_g), .chk_y(cy_g), .chk_rot(cr_g),
        .chk_ack(ack_g), .chk_hit(hit_g),
        .next_x(nx_g), .next_y(ny_g), .next_rot(nr_g),
        .pos_refresh(ref_g), .pos_respawn(resp_g), .piece_lock(lock_g), .game_over(go_g)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_g = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_down = 1'b0;
        ack_a = 1'b0; hit_a = 1'b0; ack_g = 1'b0; hit_g = 1'b0;
        cur_x = 10'd9; cur_y = 10'd5; cur_rot = 10'd0;
        repeat (2) @(negedge clk);
        check("rst_a_pulses", p_a, 5'b00000);
        check("rst_a_chk", {cx_a, cy_a, cr_a}, 30'd0);
        check("rst_a_next", {nx_a, ny_a, nr_a}, 30'd0);
        rst_a = 1'b0;

        // Right move from x=9 is checked and committed.
        @(negedge clk); btn_right = 1'b1;
        @(negedge clk);
        check("right_no_req_yet", p_a, 5'b00000);
        @(negedge clk);
        check("right_req", p_a, 5'b10000);
        check("right_chk", {cx_a, cy_a, cr_a}, {10'd10, 10'd5, 10'd0});
        ack_a = 1'b1; hit_a = 1'b0;
        @(negedge clk); ack_a = 1'b0;
        check("right_refresh", p_a, 5'b01000);
        check("right_next", {nx_a, ny_a, nr_a}, {10'd10, 10'd5, 10'd0});
        @(negedge clk);
        check("right_refresh_pulse_end", p_a, 5'b00000);
        btn_right = 1'b0;

        // Left at x=0 is discarded.
        cur_x = 10'd0;
        @(negedge clk); btn_left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("left_edge_blocked", p_a, 5'b00000);
        end
        btn_left = 1'b0;
        @(negedge clk);

        // Rotation 3 wraps to 0; a rotate hit returns silently to idle.
        cur_rot = 10'd3; btn_rot = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rot_wrap_req", p_a, 5'b10000);
        check("rot_wrap_chk", {cx_a, cy_a, cr_a}, {10'd0, 10'd5, 10'd0});
        ack_a = 1'b1; hit_a = 1'b1;
        @(negedge clk); ack_a = 1'b0; hit_a = 1'b0;
        check("rot_hit_silent", p_a, 5'b00000);
        check("rot_hit_next_held", {nx_a, ny_a, nr_a}, {10'd10, 10'd5, 10'd0});
        btn_rot = 1'b0;
        @(negedge clk);

        // Simultaneous rot+left: rotate wins, left edge is lost.
        cur_x = 10'd4; cur_y = 10'd4; cur_rot = 10'd2;
        btn_rot = 1'b1; btn_left = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("prio_req", p_a, 5'b10000);
        check("prio_chk", {cx_a, cy_a, cr_a}, {10'd4, 10'd4, 10'd3});
        ack_a = 1'b1; hit_a = 1'b0;
        @(negedge clk); ack_a = 1'b0;
        check("prio_refresh", p_a, 5'b01000);
        check("prio_next", {nx_a, ny_a, nr_a}, {10'd4, 10'd4, 10'd3});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prio_left_lost", p_a, 5'b00000);
        end
        btn_rot = 1'b0; btn_left = 1'b0;
        @(negedge clk);

        // Reset during a soft-drop handshake aborts it; a stale ack is ignored.
        cur_x = 10'd9; cur_y = 10'd5; cur_rot = 10'd0;
        btn_down = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("down_req", p_a, 5'b10000);
        check("down_chk", {cx_a, cy_a, cr_a}, {10'd9, 10'd6, 10'd0});
        rst_a = 1'b1;
        #1;
        check("rst_async_req_drop", p_a, 5'b00000);
        btn_down = 1'b0; ack_a = 1'b1; hit_a = 1'b0;
        @(negedge clk); rst_a = 1'b0;
        @(negedge clk); ack_a = 1'b0;
        check("stale_ack_ignored", p_a, 5'b00000);
        check("stale_ack_next", {nx_a, ny_a, nr_a}, 30'd0);
        btn_right = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_idle_req", p_a, 5'b10000);
        check("post_rst_chk", {cx_a, cy_a, cr_a}, {10'd10, 10'd5, 10'd0});
        ack_a = 1'b1;
        @(negedge clk); ack_a = 1'b0;
        check("post_rst_refresh", p_a, 5'b01000);
        btn_right = 1'b0;

        // Gravity instance: fall, lock on hit, spawn check hit -> game over.
        rst_a = 1'b1;
        cur_x = 10'd9; cur_y = 10'd7; cur_rot = 10'd1;
        @(negedge clk);
        check("rst_g_pulses", p_g, 5'b00000);
        rst_g = 1'b0;
        found = 1'b0;
        for (int i = 1; i <= 5 && !found; i++) begin
            @(negedge clk);
            if (req_g) found = 1'b1;
        end
        check("grav_req_within_5", found, 1'b1);
        check("grav_chk", {cx_g, cy_g, cr_g}, {10'd9, 10'd8, 10'd1});
        ack_g = 1'b1; hit_g = 1'b1;
        @(negedge clk); ack_g = 1'b0; hit_g = 1'b0;
        check("lock_pulses", p_g, 5'b00110);
        @(negedge clk);
        check("spawn_req", p_g, 5'b10000);
        check("spawn_chk", {cx_g, cy_g, cr_g}, {10'd9, 10'd0, 10'd0});
        ack_g = 1'b1; hit_g = 1'b1;
        @(negedge clk); ack_g = 1'b0; hit_g = 1'b0;
        check("game_over_set", p_g, 5'b00001);
        for (int i = 0; i < 10; i++) begin
            btn_rot = i[0]; btn_left = ~i[0]; btn_down = i[0]; btn_right = i[1];
            @(negedge clk);
            check("game_over_sticky", p_g, 5'b00001);
        end
        btn_rot = 1'b0; btn_left = 1'b0; btn_down = 1'b0; btn_right = 1'b0;
        rst_g = 1'b1;
        #1;
        check("game_over_async_clear", go_g, 1'b0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
